// File: rtl/mult_arb_pkg.sv
// Shared types and the round-robin pick function for the multiplier-sharing arbiter.
package mult_arb_pkg;

    // Largest requester count the pick function can search.
    localparam int MAX_REQ = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic        found;
        logic [31:0] idx;
    } pick_t;

    // First set bit of valid, searching from ptr upward and wrapping at nreq.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                      input int unsigned       ptr,
                                      input int unsigned       nreq);
        pick_t       r;
        int unsigned j;
        r.found = 1'b0;
        r.idx   = '0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            if (k < nreq) begin
                j = ptr + k;
                if (j >= nreq) j = j - nreq;
                if (!r.found && valid[j[4:0]]) begin
                    r.found = 1'b1;
                    r.idx   = j;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mult_core.sv
// Registered unsigned W x W multiplier; updates only when enabled.
module mult_core #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] y
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            y <= '0;
        end else if (en) begin
            y <= a * b;
        end
    end

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter time-sharing one registered multiplier among NREQ requesters.
module mult_share_arbiter
    import mult_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [2*W-1:0]    rsp_y,
    output logic [IDW-1:0]    rsp_id,
    output logic              busy
);

    state_t             state;
    state_t             state_next;
    logic [IDW-1:0]     rr_ptr;
    logic [IDW-1:0]     rr_ptr_next;
    logic [MAX_REQ-1:0] valid_ext;
    pick_t              pick;
    logic [IDW-1:0]     grant_id;
    logic               accept;
    logic               core_en;

    logic [W-1:0]       a_p0;
    logic [W-1:0]       b_p0;
    logic [IDW-1:0]     id_p0;

    always_comb begin
        valid_ext               = '0;
        valid_ext[NREQ-1:0]     = req_valid;
        pick                    = rr_pick(valid_ext, 32'(rr_ptr), NREQ);
    end

    assign grant_id = IDW'(pick.idx);
    assign accept   = (state == IDLE) && pick.found;
    assign core_en  = (state == MUL);
    assign busy     = (state != IDLE);

    // Grant is combinational so a requester sees ready in the same cycle it asserts valid.
    always_comb begin
        req_ready = '0;
        if (rst && accept) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_next = (rsp_id == IDW'(NREQ - 1)) ? '0 : rsp_id + 1'b1;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = MUL;
            MUL:     state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
        end else begin
            state <= state_next;
            if (state == MUL) begin
                rsp_valid <= 1'b1;
                rsp_id    <= id_p0;
            end else if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
                rr_ptr    <= rr_ptr_next;
            end
        end
    end

    // Stage p0: operands captured at the accept edge only
    always_ff @(posedge clk) begin
        if (accept) begin
            a_p0  <= req_a[grant_id*W +: W];
            b_p0  <= req_b[grant_id*W +: W];
            id_p0 <= grant_id;
        end
    end

    // Stage p1: product registered during MUL and held as the response payload
    mult_core #(
        .W (W)
    ) u_core (
        .clk (clk),
        .rst (rst),
        .en  (core_en),
        .a   (a_p0),
        .b   (b_p0),
        .y   (rsp_y)
    );

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed self-checking bench for mult_share_arbiter.
module tb_mult_share_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [2*W-1:0]    rsp_y;
    logic [IDW-1:0]    rsp_id;
    logic              busy;

    int n_cmp  = 0;
    int n_fail = 0;

    mult_share_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_y     (rsp_y),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input int a, input int b);
        req_a[i*W +: W] = W'(a);
        req_b[i*W +: W] = W'(b);
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        req_valid = '1;
        req_a     = '1;
        req_b     = '1;
        rsp_ready = 1'b0;
        tick();
        tick();
        n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        n_cmp++; if (rsp_y !== 8'd0) begin n_fail++; $display("FAIL reset_rsp_y got %0d want 0", rsp_y); end
        n_cmp++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL reset_rsp_id got %0d want 0", rsp_id); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        req_valid = '0;
        rst       = 1'b1;
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy got %b want 0", busy); end
    endtask

    task automatic test_single();
        set_op(0, 3, 5);
        req_valid = 4'b0001;
        rsp_ready = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_ready got %b want 0001", req_ready); end
        tick();
        req_valid = '0;
        #1;
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_mul got %b want 1", busy); end
        n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL single_ready_mul got %b want 0000", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_mul got %b want 0", rsp_valid); end
        tick();
        n_cmp++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", rsp_valid); end
        n_cmp++; if (rsp_y !== 8'd15) begin n_fail++; $display("FAIL single_y got %0d want 15", rsp_y); end
        n_cmp++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL single_id got %0d want 0", rsp_id); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_resp got %b want 1", busy); end
        rsp_ready = 1'b1;
        tick();
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_done_valid got %b want 0", rsp_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_done_busy got %b want 0", busy); end
        rsp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [2*W-1:0] exp_y  [5] = '{8'd2, 8'd6, 8'd12, 8'd20, 8'd2};
        logic [IDW-1:0] exp_id [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [NREQ-1:0] exp_rdy;
        rst = 1'b0;
        #1;
        rst = 1'b1;
        for (int i = 0; i < NREQ; i++) set_op(i, i + 1, i + 2);
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            #1;
            exp_rdy = 4'b0001 << exp_id[n];
            n_cmp++; if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL b2b_ready[%0d] got %b want %b", n, req_ready, exp_rdy); end
            tick();
            n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL b2b_ready_mul[%0d] got %b want 0000", n, req_ready); end
            tick();
            n_cmp++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d] got %b want 1", n, rsp_valid); end
            n_cmp++; if (rsp_y !== exp_y[n]) begin n_fail++; $display("FAIL b2b_y[%0d] got %0d want %0d", n, rsp_y, exp_y[n]); end
            n_cmp++; if (rsp_id !== exp_id[n]) begin n_fail++; $display("FAIL b2b_id[%0d] got %0d want %0d", n, rsp_id, exp_id[n]); end
            if (n == 4) req_valid = '0;
            tick();
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        set_op(1, 15, 15);
        req_valid = 4'b0010;
        #1;
        n_cmp++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_ready got %b want 0010", req_ready); end
        tick();
        req_valid = 4'b1111;
        tick();
        for (int c = 0; c < 5; c++) begin
            n_cmp++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d] got %b want 1", c, rsp_valid); end
            n_cmp++; if (rsp_y !== 8'd225) begin n_fail++; $display("FAIL bp_y[%0d] got %0d want 225", c, rsp_y); end
            n_cmp++; if (rsp_id !== 2'd1) begin n_fail++; $display("FAIL bp_id[%0d] got %0d want 1", c, rsp_id); end
            n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready_hold[%0d] got %b want 0000", c, req_ready); end
            tick();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        tick();
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_done got %b want 0", rsp_valid); end
        rsp_ready = 1'b0;
    endtask

    task automatic test_wrap();
        set_op(2, 2, 3);
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL wrap_ready2 got %b want 0100", req_ready); end
        tick();
        req_valid = '0;
        tick();
        n_cmp++; if (rsp_y !== 8'd6) begin n_fail++; $display("FAIL wrap_y2 got %0d want 6", rsp_y); end
        tick();
        set_op(3, 5, 3);
        set_op(0, 6, 2);
        req_valid = 4'b1001;
        #1;
        n_cmp++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL wrap_ready3 got %b want 1000", req_ready); end
        tick();
        tick();
        n_cmp++; if (rsp_id !== 2'd3) begin n_fail++; $display("FAIL wrap_id3 got %0d want 3", rsp_id); end
        n_cmp++; if (rsp_y !== 8'd15) begin n_fail++; $display("FAIL wrap_y3 got %0d want 15", rsp_y); end
        tick();
        n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL wrap_ready0 got %b want 0001", req_ready); end
        tick();
        tick();
        n_cmp++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL wrap_id0 got %0d want 0", rsp_id); end
        n_cmp++; if (rsp_y !== 8'd12) begin n_fail++; $display("FAIL wrap_y0 got %0d want 12", rsp_y); end
        req_valid = '0;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_operand_change();
        set_op(0, 7, 9);
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL opchg_ready got %b want 0001", req_ready); end
        tick();
        req_a     = '0;
        req_b     = '0;
        req_valid = '0;
        tick();
        n_cmp++; if (rsp_y !== 8'd63) begin n_fail++; $display("FAIL opchg_y got %0d want 63", rsp_y); end
        n_cmp++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL opchg_id got %0d want 0", rsp_id); end
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_midop();
        set_op(2, 4, 4);
        req_valid = 4'b0100;
        rsp_ready = 1'b0;
        tick();
        req_valid = '0;
        tick();
        n_cmp++; if (rsp_y !== 8'd16) begin n_fail++; $display("FAIL midop_pre_y got %0d want 16", rsp_y); end
        set_op(0, 3, 3);
        req_valid = 4'b0101;
        #2;
        rst = 1'b0;
        #1;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL midop_valid got %b want 0", rsp_valid); end
        n_cmp++; if (rsp_y !== 8'd0) begin n_fail++; $display("FAIL midop_y got %0d want 0", rsp_y); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midop_busy got %b want 0", busy); end
        n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL midop_ready got %b want 0000", req_ready); end
        rst = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL midop_post_ready got %b want 0001", req_ready); end
        rsp_ready = 1'b1;
        tick();
        req_valid = '0;
        tick();
        n_cmp++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL midop_post_id got %0d want 0", rsp_id); end
        n_cmp++; if (rsp_y !== 8'd9) begin n_fail++; $display("FAIL midop_post_y got %0d want 9", rsp_y); end
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_wrap();
        test_operand_change();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
